// File: rtl/dmem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dmem_arbiter_pkg
// Description : Shared types for the data-memory arbiter: FSM states, response
//               owner encoding and the request bundle used by both ports.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_arbiter_pkg;

  localparam int DMEM_XLEN = 32;
  localparam int DMEM_AW   = 11;

  typedef enum logic [1:0] {
    ARB     = 2'd0,
    D_PRIO  = 2'd1,
    D_LOCK  = 2'd2,
    C_FORCE = 2'd3
  } arb_state_e;

  typedef enum logic {
    OWN_C = 1'b0,
    OWN_D = 1'b1
  } arb_owner_e;

  typedef struct packed {
    logic                 we;
    logic [3:0]           be;
    logic [DMEM_AW-1:0]   addr;
    logic [DMEM_XLEN-1:0] wdata;
  } dmem_req_t;

endpackage
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Shares the single-port data memory between the core MEM stage
//               (port C) and the debug/loader DMA (port D). One grant per
//               cycle, core priority with starvation relief and locked D
//               bursts, registered one-cycle read/ack response.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  // XLEN/AW must match the package request struct widths.
  parameter int XLEN         = DMEM_XLEN,
  parameter int AW           = DMEM_AW,
  // Both limits are expected to be at least 2.
  parameter int STARVE_LIMIT = 4,
  parameter int MAX_LOCK     = 8
) (
  input  logic            clk_i,
  input  logic            rst_i,
  // core port
  input  logic            c_valid_i,
  output logic            c_ready_o,
  input  logic            c_we_i,
  input  logic [3:0]      c_be_i,
  input  logic [AW-1:0]   c_addr_i,
  input  logic [XLEN-1:0] c_wdata_i,
  output logic            c_rvalid_o,
  output logic [XLEN-1:0] c_rdata_o,
  output logic            c_stall_o,
  // debug / DMA port
  input  logic            d_valid_i,
  output logic            d_ready_o,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [AW-1:0]   d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  input  logic            d_lock_i,
  // memory port
  output logic            mem_en_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [AW-1:0]   mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic [XLEN-1:0] mem_rdata_i
);

  localparam int STARVE_W = $clog2(STARVE_LIMIT);
  localparam int LOCK_W   = $clog2(MAX_LOCK);
  localparam logic [STARVE_W-1:0] STARVE_LAST = STARVE_W'(STARVE_LIMIT - 1);
  localparam logic [LOCK_W-1:0]   LOCK_LAST   = LOCK_W'(MAX_LOCK - 1);

  arb_state_e           state, next_state;
  logic [STARVE_W-1:0]  starve_cnt, starve_nxt;
  logic [LOCK_W-1:0]    lock_cnt, lock_nxt;
  logic                 grant_c, grant_d;
  dmem_req_t            c_req, d_req, gnt_req;
  logic                 rsp_vld_q, rsp_we_q;
  arb_owner_e           rsp_own_q;

  assign c_req = '{we: c_we_i, be: c_be_i, addr: c_addr_i, wdata: c_wdata_i};
  assign d_req = '{we: d_we_i, be: d_be_i, addr: d_addr_i, wdata: d_wdata_i};

  // Grant selection and next-state/counter update; nothing is granted in reset.
  always_comb begin
    next_state = state;
    starve_nxt = starve_cnt;
    lock_nxt   = lock_cnt;
    grant_c    = 1'b0;
    grant_d    = 1'b0;
    if (!rst_i) begin
      case (state)
        ARB: begin
          if (c_valid_i)      grant_c = 1'b1;
          else if (d_valid_i) grant_d = 1'b1;
          if (grant_d) begin
            starve_nxt = '0;
            if (d_lock_i) begin
              next_state = D_LOCK;
              lock_nxt   = LOCK_W'(1);
            end
          end else if (d_valid_i) begin
            // D lost this cycle; once the wait count reaches its last value
            // the next cycle belongs to D.
            if (starve_cnt != STARVE_LAST) starve_nxt = starve_cnt + STARVE_W'(1);
            if (starve_nxt == STARVE_LAST) next_state = D_PRIO;
          end else begin
            starve_nxt = '0;
          end
        end
        D_PRIO: begin
          starve_nxt = '0;
          if (d_valid_i) begin
            grant_d = 1'b1;
            if (d_lock_i) begin
              next_state = D_LOCK;
              lock_nxt   = LOCK_W'(1);
            end else begin
              next_state = ARB;
            end
          end else begin
            // D withdrew its request: the slot falls back to the core.
            grant_c    = c_valid_i;
            next_state = ARB;
          end
        end
        D_LOCK: begin
          if (d_valid_i && d_lock_i) begin
            grant_d = 1'b1;
            if (lock_cnt == LOCK_LAST) begin
              // This is the MAX_LOCK-th consecutive locked grant.
              lock_nxt   = '0;
              next_state = c_valid_i ? C_FORCE : ARB;
            end else begin
              lock_nxt = lock_cnt + LOCK_W'(1);
            end
          end else begin
            lock_nxt   = '0;
            next_state = c_valid_i ? C_FORCE : ARB;
          end
        end
        C_FORCE: begin
          grant_c    = c_valid_i;
          lock_nxt   = '0;
          next_state = ARB;
        end
        default: next_state = ARB;
      endcase
    end
  end

  // Memory port mirrors the granted request; zeroed when idle.
  always_comb begin
    gnt_req = '0;
    if (grant_c)      gnt_req = c_req;
    else if (grant_d) gnt_req = d_req;
  end

  assign c_ready_o   = grant_c;
  assign d_ready_o   = grant_d;
  assign c_stall_o   = c_valid_i & ~grant_c & ~rst_i;
  assign mem_en_o    = grant_c | grant_d;
  assign mem_we_o    = gnt_req.we;
  assign mem_be_o    = gnt_req.be;
  assign mem_addr_o  = gnt_req.addr;
  assign mem_wdata_o = gnt_req.wdata;

  // FSM, counters and the one-deep response pipeline.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= ARB;
      starve_cnt <= '0;
      lock_cnt   <= '0;
      rsp_vld_q  <= 1'b0;
      rsp_own_q  <= OWN_C;
      rsp_we_q   <= 1'b0;
    end else begin
      state      <= next_state;
      starve_cnt <= starve_nxt;
      lock_cnt   <= lock_nxt;
      rsp_vld_q  <= grant_c | grant_d;
      rsp_own_q  <= grant_d ? OWN_D : OWN_C;
      rsp_we_q   <= gnt_req.we;
    end
  end

  // Response is steered to its owner; a response caught by reset is suppressed.
  always_comb begin
    c_rvalid_o = rsp_vld_q & (rsp_own_q == OWN_C) & ~rst_i;
    d_rvalid_o = rsp_vld_q & (rsp_own_q == OWN_D) & ~rst_i;
    c_rdata_o  = (c_rvalid_o && !rsp_we_q) ? mem_rdata_i : '0;
    d_rdata_o  = (d_rvalid_o && !rsp_we_q) ? mem_rdata_i : '0;
  end

endmodule
`default_nettype wire
